// File: rtl/urv_exec_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU in the uRV execute stage.
// Optional build macro: URV_DIV_EARLY_OUT_EN (skip iterations when |rs1| < |rs2|).
module urv_exec_divider #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            x_stall_req_o,
    input  logic            d_valid_i,
    input  logic            d_is_divide_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_done_o
);

    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StFixup, StDone} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              is_rem_q, is_rem_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              stall, done;

    logic              start, sgn, rs1_neg, rs2_neg, div0, ovf;
    logic [XLEN-1:0]   abs1, abs2;
    logic              unused_fun;

    // funct3[2] is implied by d_is_divide_i.
    assign unused_fun = d_fun_i[2];

    always_comb begin
        start   = d_valid_i & d_is_divide_i & ~x_kill_i;
        sgn     = ~d_fun_i[0];
        rs1_neg = sgn & d_rs1_i[XLEN-1];
        rs2_neg = sgn & d_rs2_i[XLEN-1];
        abs1    = rs1_neg ? -d_rs1_i : d_rs1_i;
        abs2    = rs2_neg ? -d_rs2_i : d_rs2_i;
        div0    = (d_rs2_i == '0);
        ovf     = sgn & (d_rs1_i == MinVal) & (d_rs2_i == '1);
    end

    // Restoring steps chained combinationally; shifted value is XLEN+1 bits wide.
    logic [XLEN-1:0] sq [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] sr [BITS_PER_CYCLE+1];
    logic [XLEN:0]   trial;

    always_comb begin
        trial = '0;
        sq[0] = q_q;
        sr[0] = r_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            trial = {sr[i], sq[i][XLEN-1]} - {1'b0, div_q};
            if (!trial[XLEN]) begin
                sr[i+1] = trial[XLEN-1:0];
                sq[i+1] = {sq[i][XLEN-2:0], 1'b1};
            end else begin
                sr[i+1] = {sr[i][XLEN-2:0], sq[i][XLEN-1]};
                sq[i+1] = {sq[i][XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        r_d      = r_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        rd_d     = rd_q;
        stall    = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    stall    = 1'b1;
                    div_d    = abs2;
                    cnt_d    = CW'(N);
                    // Divide-by-zero keeps the all-ones quotient unsigned.
                    q_neg_d  = (rs1_neg ^ rs2_neg) & ~div0;
                    r_neg_d  = rs1_neg;
                    is_rem_d = d_fun_i[1];
                    if (div0) begin
                        q_d     = '1;
                        r_d     = abs1;
                        state_d = StFixup;
                    end else if (ovf) begin
                        q_d     = MinVal;
                        r_d     = '0;
                        state_d = StFixup;
`ifdef URV_DIV_EARLY_OUT_EN
                    end else if (abs1 < abs2) begin
                        q_d     = '0;
                        r_d     = abs1;
                        state_d = StFixup;
`endif
                    end else begin
                        q_d     = abs1;
                        r_d     = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                q_d   = sq[BITS_PER_CYCLE];
                r_d   = sr[BITS_PER_CYCLE];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                stall = 1'b1;
                if (is_rem_q) begin
                    rd_d = r_neg_q ? -r_q : r_q;
                end else begin
                    rd_d = q_neg_q ? -q_q : q_q;
                end
                state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (!x_stall_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (x_kill_i) begin
            state_d = StIdle;
            rd_d    = rd_q;
            stall   = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            q_q      <= '0;
            r_q      <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            r_q      <= r_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            rd_q     <= rd_d;
        end
    end

    assign x_stall_req_o = stall & ~rst_i;
    assign x_done_o      = done & ~rst_i;
    assign x_rd_o        = rd_q;

endmodule

// File: tb/tb_urv_exec_divider.sv
// Directed bench for urv_exec_divider: radix-1 and radix-4 instances share operands.
module tb_urv_exec_divider;

    localparam logic [2:0] FDiv = 3'b100, FDivu = 3'b101, FRem = 3'b110, FRemu = 3'b111;
`ifdef URV_DIV_EARLY_OUT_EN
    localparam int EoStall = 2;
`else
    localparam int EoStall = 34;
`endif

    logic        clk = 1'b0;
    logic        rst, x_stall, x_kill, valid1, valid4, is_div;
    logic [2:0]  fun;
    logic [31:0] rs1, rs2;
    logic        stall1, done1, stall4, done4;
    logic [31:0] rd1, rd4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    urv_exec_divider #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall1), .d_valid_i(valid1), .d_is_divide_i(is_div),
        .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd1), .x_done_o(done1)
    );

    urv_exec_divider #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall4), .d_valid_i(valid4), .d_is_divide_i(is_div),
        .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd4), .x_done_o(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, count stall cycles, optionally hold DONE with x_stall, then retire.
    task automatic run_op(input bit wide, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input int exp_stall, input bit hold, input string tag);
        int cyc;
        fun = f; rs1 = a; rs2 = b; is_div = 1'b1;
        if (wide) valid4 = 1'b1; else valid1 = 1'b1;
        #1;
        cyc = 0;
        while ((wide ? stall4 : stall1) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " stall"}, cyc, exp_stall);
        check({tag, " done"}, {31'b0, wide ? done4 : done1}, 32'd1);
        check({tag, " rd"}, wide ? rd4 : rd1, exp_rd);
        if (hold) begin
            x_stall = 1'b1;
            @(posedge clk); #1;
            check({tag, " held done"}, {31'b0, wide ? done4 : done1}, 32'd1);
            check({tag, " held rd"}, wide ? rd4 : rd1, exp_rd);
            check({tag, " held req"}, {31'b0, wide ? stall4 : stall1}, 32'd0);
            x_stall = 1'b0;
        end
        @(posedge clk); #1;
        valid1 = 1'b0; valid4 = 1'b0;
        check({tag, " retire"}, {31'b0, wide ? done4 : done1}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; x_stall = 1'b0; x_kill = 1'b0; valid1 = 1'b0; valid4 = 1'b0;
        is_div = 1'b0; fun = 3'b0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset req1", {31'b0, stall1}, 32'd0);
        check("reset done1", {31'b0, done1}, 32'd0);
        check("reset rd1", rd1, 32'd0);
        check("reset req4", {31'b0, stall4}, 32'd0);
        check("reset done4", {31'b0, done4}, 32'd0);
        check("reset rd4", rd4, 32'd0);

        // Non-divide instruction must not start.
        valid1 = 1'b1; is_div = 1'b0; fun = FDivu; rs1 = 32'd10; rs2 = 32'd2;
        #1 check("nondiv req", {31'b0, stall1}, 32'd0);
        @(posedge clk); #1 valid1 = 1'b0;

        run_op(1'b0, FDivu, 32'd100, 32'd7, 32'd14, 34, 1'b1, "divu 100/7");
        run_op(1'b0, FRemu, 32'd100, 32'd7, 32'd2, 34, 1'b0, "remu 100/7");
        run_op(1'b0, FDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, "div -7/2");
        run_op(1'b0, FRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, "rem -7/2");
        run_op(1'b0, FRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0, "rem 7/-2");
        run_op(1'b0, FDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0, "div 5/0");
        run_op(1'b0, FRemu, 32'd5, 32'd0, 32'd5, 2, 1'b0, "remu 5/0");
        run_op(1'b0, FRem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, 1'b0, "rem -5/0");
        run_op(1'b0, FDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0, "div ovf");
        run_op(1'b0, FRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0, "rem ovf");

        // Kill in the 10th BUSY cycle.
        fun = FDivu; rs1 = 32'd1000; rs2 = 32'd3; is_div = 1'b1; valid1 = 1'b1;
        repeat (10) @(posedge clk);
        #1 x_kill = 1'b1;
        #1;
        check("kill req", {31'b0, stall1}, 32'd0);
        check("kill done", {31'b0, done1}, 32'd0);
        @(posedge clk); #1;
        x_kill = 1'b0; valid1 = 1'b0;
        #1 check("post-kill idle", {31'b0, stall1}, 32'd0);
        @(posedge clk); #1;
        run_op(1'b0, FDivu, 32'd9, 32'd3, 32'd3, 34, 1'b0, "divu 9/3");

        run_op(1'b0, FDivu, 32'd3, 32'd10, 32'd0, EoStall, 1'b0, "divu 3/10");
        run_op(1'b0, FRemu, 32'd3, 32'd10, 32'd3, EoStall, 1'b0, "remu 3/10");

        run_op(1'b1, FDivu, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 10, 1'b0, "r4 divu");
        run_op(1'b1, FDiv, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 10, 1'b0, "r4 div -5/3");
        run_op(1'b1, FRem, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFE, 10, 1'b0, "r4 rem -5/3");
        run_op(1'b1, FRemu, 32'd12345, 32'd100, 32'd45, 10, 1'b0, "r4 remu");

        // Reset in the middle of an operation clears everything.
        fun = FDivu; rs1 = 32'd100; rs2 = 32'd7; is_div = 1'b1; valid1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst req", {31'b0, stall1}, 32'd0);
        check("midrst done", {31'b0, done1}, 32'd0);
        check("midrst rd", rd1, 32'd0);
        valid1 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("midrst idle", {31'b0, stall1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
